sm83_irq_ctl: RTL and testbench

Interrupt controller and dispatch sequencer for the SM83 core. It holds the IF and IE registers and the IME master enable, including the EI one-instruction delay. It resolves fixed interrupt priority and sequences the 5-M-cycle interrupt dispatch, telling the core when to push PC and which vector to load. It also manages HALT entry and wake, and sits between the peripherals' request lines and the core control FSM.

---
 rtl/sm83_irq_ctl.sv | 162 ++++++++++++++++
 tb/tb_sm83_irq_ctl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm83_irq_ctl.sv
// SM83 interrupt controller: IF/IE/IME, EI delay, priority, 5-step dispatch.
// Ports: clk/rst, step, irq_req, if/ie regs, ei/di/reti, halt, dispatch outs.
module sm83_irq_ctl (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [4:0]  irq_req,
  input  logic        if_wr,
  input  logic        ie_wr,
  input  logic [7:0]  wdata,
  output logic [7:0]  if_rdata,
  output logic [7:0]  ie_rdata,
  input  logic        ei,
  input  logic        di,
  input  logic        reti,
  input  logic        instr_boundary,
  input  logic        halt_req,
  output logic        dispatch,
  output logic        busy,
  output logic        push_hi,
  output logic        push_lo,
  output logic        jump,
  output logic [15:0] vector,
  output logic        halted,
  output logic        halt_bug,
  output logic        ime
);

  typedef enum logic [2:0] {
    S_IDLE, S_W1, S_W2, S_PUSH_HI, S_PUSH_LO, S_JUMP
  } state_t;

  state_t      state;
  logic [4:0]  if_q, if_d;
  logic [7:0]  ie_q, ie_d;
  logic        ime_q, ime_pend;
  logic [2:0]  idx_q;
  logic        sel_ok;
  logic [15:0] vec_q;
  logic        busy_q, ph_q, pl_q, jmp_q;
  logic        halted_q, hbug_q;
  logic [4:0]  pending, pend_nx;
  logic        clr;

  function automatic logic [2:0] lowest(input logic [4:0] p);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (p[i]) r = 3'(i);
    return r;
  endfunction

  assign pending = ie_q[4:0] & if_q;
  // IE/IF as they will be after this clk, so a write on the
  // edge that ends PUSH_HI still steers the vector choice.
  assign pend_nx = ie_d[4:0] & if_d;
  assign clr = step && (state == S_PUSH_LO) && sel_ok;

  // Request OR is applied last so a request never loses to a clear/write.
  always_comb begin
    if_d = if_q;
    if (clr) if_d[idx_q] = 1'b0;
    if (if_wr) if_d = wdata[4:0];
    if_d = if_d | irq_req;
    ie_d = ie_wr ? wdata : ie_q;
  end

  assign dispatch = (state == S_IDLE) && instr_boundary &&
                    ime_q && (|pending);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      if_q     <= 5'd0;
      ie_q     <= 8'd0;
      ime_q    <= 1'b0;
      ime_pend <= 1'b0;
      idx_q    <= 3'd0;
      sel_ok   <= 1'b0;
      vec_q    <= 16'd0;
      busy_q   <= 1'b0;
      ph_q     <= 1'b0;
      pl_q     <= 1'b0;
      jmp_q    <= 1'b0;
      halted_q <= 1'b0;
      hbug_q   <= 1'b0;
    end else begin
      if_q <= if_d;
      ie_q <= ie_d;
      if (step) begin
        hbug_q <= 1'b0;
        unique case (state)
          S_IDLE: begin
            if (dispatch) begin
              state  <= S_W1;
              busy_q <= 1'b1;
            end
          end
          S_W1: state <= S_W2;
          S_W2: begin
            state <= S_PUSH_HI;
            ph_q  <= 1'b1;
          end
          S_PUSH_HI: begin
            state  <= S_PUSH_LO;
            ph_q   <= 1'b0;
            pl_q   <= 1'b1;
            idx_q  <= lowest(pend_nx);
            sel_ok <= |pend_nx;
          end
          S_PUSH_LO: begin
            state <= S_JUMP;
            pl_q  <= 1'b0;
            jmp_q <= 1'b1;
            vec_q <= sel_ok ? 16'h0040 + {10'd0, idx_q, 3'd0}
                            : 16'h0000;
          end
          S_JUMP: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            jmp_q  <= 1'b0;
            vec_q  <= 16'h0000;
          end
          default: state <= S_IDLE;
        endcase
        if (state == S_IDLE) begin
          // Dispatch sees the old IME; a pending EI lands afterwards.
          if (dispatch) begin
            ime_q    <= 1'b0;
            ime_pend <= 1'b0;
          end else if (instr_boundary && ime_pend) begin
            ime_q    <= 1'b1;
            ime_pend <= 1'b0;
          end
          if (ei) ime_pend <= 1'b1;
          if (reti) ime_q <= 1'b1;
          if (di) begin
            ime_q    <= 1'b0;
            ime_pend <= 1'b0;
          end
          if (halt_req) begin
            if (!(|pending)) halted_q <= 1'b1;
            else if (!ime_q) hbug_q <= 1'b1;
          end
        end
        if (halted_q && (|pending)) halted_q <= 1'b0;
      end
    end
  end

  assign if_rdata = {3'b111, if_q};
  assign ie_rdata = ie_q;
  assign ime      = ime_q;
  assign busy     = busy_q;
  assign push_hi  = ph_q;
  assign push_lo  = pl_q;
  assign jump     = jmp_q;
  assign vector   = vec_q;
  assign halted   = halted_q;
  assign halt_bug = hbug_q;

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// Bench for sm83_irq_ctl: directed table, hand sequences, random vs model.
// Drives all DUT ports; prints one summary line.
module tb_sm83_irq_ctl;

  logic        clk = 1'b0;
  logic        rst, step;
  logic [4:0]  irq_req;
  logic        if_wr, ie_wr;
  logic [7:0]  wdata;
  logic [7:0]  if_rdata, ie_rdata;
  logic        ei, di, reti, instr_boundary, halt_req;
  logic        dispatch, busy, push_hi, push_lo, jump;
  logic [15:0] vector;
  logic        halted, halt_bug, ime;

  always #5 clk = ~clk;

  sm83_irq_ctl dut (
    .clk(clk), .rst(rst), .step(step), .irq_req(irq_req),
    .if_wr(if_wr), .ie_wr(ie_wr), .wdata(wdata),
    .if_rdata(if_rdata), .ie_rdata(ie_rdata),
    .ei(ei), .di(di), .reti(reti),
    .instr_boundary(instr_boundary), .halt_req(halt_req),
    .dispatch(dispatch), .busy(busy),
    .push_hi(push_hi), .push_lo(push_lo), .jump(jump),
    .vector(vector), .halted(halted), .halt_bug(halt_bug), .ime(ime)
  );

  int errors = 0;
  int checks = 0;
  logic last_disp;

  // Reference model: phase counts M-cycles since dispatch (0 = idle).
  logic [4:0]  m_if;
  logic [7:0]  m_ie;
  bit          m_ime, m_pend, m_halt, m_hbug;
  int          m_phase, m_sel;
  logic [15:0] m_vec;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int lowest_idx(input logic [4:0] p);
    for (int i = 0; i < 5; i++)
      if (p[i]) return i;
    return -1;
  endfunction

  function automatic bit model_disp(input bit b);
    return (m_phase == 0) && b && m_ime && ((m_ie[4:0] & m_if) != 0);
  endfunction

  task automatic model_reset();
    m_if = 0; m_ie = 0; m_ime = 0; m_pend = 0;
    m_halt = 0; m_hbug = 0; m_phase = 0; m_sel = -1; m_vec = 0;
  endtask

  task automatic model_clk(input bit st, input logic [4:0] irq,
                           input bit ifw, input bit iew,
                           input logic [7:0] wd, input bit e,
                           input bit d, input bit r, input bit b,
                           input bit h);
    logic [4:0] nif;
    logic [7:0] nie;
    logic [4:0] pend;
    bit idle, disp, old_halt, old_ime;
    pend = m_ie[4:0] & m_if;
    idle = (m_phase == 0);
    disp = model_disp(b);
    old_halt = m_halt;
    old_ime = m_ime;
    nif = m_if;
    nie = m_ie;
    if (st && m_phase == 4 && m_sel >= 0) nif[m_sel] = 1'b0;
    if (ifw) nif = wd[4:0];
    if (iew) nie = wd;
    nif = nif | irq;
    if (st) begin
      if (m_phase == 3) m_sel = lowest_idx(nie[4:0] & nif);
      if (m_phase == 4) m_vec = (m_sel < 0) ? 16'h0 : 16'(64 + 8 * m_sel);
      if (disp) m_phase = 1;
      else if (!idle) m_phase = (m_phase + 1) % 6;
      m_hbug = 0;
      if (idle) begin
        if (h && pend == 0) m_halt = 1;
        if (h && pend != 0 && !old_ime) m_hbug = 1;
        if (disp) begin m_ime = 0; m_pend = 0; end
        else if (b && m_pend) begin m_ime = 1; m_pend = 0; end
        if (e) m_pend = 1;
        if (r) m_ime = 1;
        if (d) begin m_ime = 0; m_pend = 0; end
      end
      if (old_halt && pend != 0) m_halt = 0;
    end
    m_if = nif;
    m_ie = nie;
  endtask

  task automatic cmp_model();
    check("if_rdata", if_rdata, {3'b111, m_if});
    check("ie_rdata", ie_rdata, m_ie);
    check("ime", ime, m_ime);
    check("busy", busy, m_phase != 0);
    check("push_hi", push_hi, m_phase == 3);
    check("push_lo", push_lo, m_phase == 4);
    check("jump", jump, m_phase == 5);
    check("vector", vector, (m_phase == 5) ? m_vec : 16'h0);
    check("halted", halted, m_halt);
    check("halt_bug", halt_bug, m_hbug);
  endtask

  task automatic apply(input bit st, input logic [4:0] irq,
                       input bit ifw, input bit iew,
                       input logic [7:0] wd, input bit e, input bit d,
                       input bit r, input bit b, input bit h);
    step = st; irq_req = irq; if_wr = ifw; ie_wr = iew; wdata = wd;
    ei = e; di = d; reti = r; instr_boundary = b; halt_req = h;
    #1;
    last_disp = dispatch;
    check("dispatch", dispatch, model_disp(b));
    model_clk(st, irq, ifw, iew, wd, e, d, r, b, h);
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    rst = 1; step = 0; irq_req = 0; if_wr = 0; ie_wr = 0; wdata = 0;
    ei = 0; di = 0; reti = 0; instr_boundary = 0; halt_req = 0;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    cmp_model();
  endtask

  typedef enum {NOP, WIE, WIF, EI, DI, RETI, BND, HLT, IRQ} op_e;
  typedef struct {
    op_e op; int val;
    int xd; int xb; int xi; int xv; int xm; int xh; int xg;
  } row_t;
  localparam int N = -1;
  row_t tbl[$];

  task automatic run_row(input row_t t);
    logic [7:0] v;
    v = 8'(t.val);
    apply(1'b1, (t.op == IRQ) ? v[4:0] : 5'd0,
          t.op == WIF, t.op == WIE, v, t.op == EI, t.op == DI,
          t.op == RETI, t.op == BND, t.op == HLT);
    if (t.xd != N) check("t_disp", last_disp, t.xd);
    if (t.xb != N) check("t_busy", busy, t.xb);
    if (t.xi != N) check("t_if", if_rdata, t.xi);
    if (t.xv != N) check("t_vec", vector, t.xv);
    if (t.xm != N) check("t_ime", ime, t.xm);
    if (t.xh != N) check("t_halt", halted, t.xh);
    if (t.xg != N) check("t_hbug", halt_bug, t.xg);
  endtask

  initial begin
    // dispatch and vector
    tbl.push_back('{WIE, 'h05, N, 0, 'hE0, N, 0, N, N});
    tbl.push_back('{WIF, 'h04, N, 0, 'hE4, N, 0, N, N});
    tbl.push_back('{RETI, 0, N, 0, 'hE4, N, 1, N, N});
    tbl.push_back('{BND, 0, 1, 1, 'hE4, 0, 0, N, N});
    tbl.push_back('{NOP, 0, 0, 1, N, 0, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, N, 0, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, 'hE4, 0, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, 'hE0, 'h50, 0, N, N});
    tbl.push_back('{NOP, 0, N, 0, 'hE0, 0, 0, N, N});
    // priority, then repeat after reti
    tbl.push_back('{WIE, 'h1F, N, 0, N, N, N, N, N});
    tbl.push_back('{WIF, 'h1A, N, 0, 'hFA, N, 0, N, N});
    tbl.push_back('{RETI, 0, N, 0, N, N, 1, N, N});
    tbl.push_back('{BND, 0, 1, 1, N, N, 0, N, N});
    tbl.push_back('{NOP, 0, N, 1, N, N, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, N, N, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, 'hFA, 0, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, 'hF8, 'h48, N, N, N});
    tbl.push_back('{NOP, 0, N, 0, 'hF8, 0, N, N, N});
    tbl.push_back('{RETI, 0, N, 0, N, N, 1, N, N});
    tbl.push_back('{BND, 0, 1, 1, N, N, 0, N, N});
    tbl.push_back('{NOP, 0, N, 1, N, N, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, N, N, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, N, N, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, 'hF0, 'h58, N, N, N});
    tbl.push_back('{NOP, 0, N, 0, N, 0, N, N, N});
    // EI delay, then EI cancelled by DI
    tbl.push_back('{EI, 0, N, 0, N, N, 0, N, N});
    tbl.push_back('{BND, 0, 0, 0, N, N, 1, N, N});
    tbl.push_back('{BND, 0, 1, 1, N, N, 0, N, N});
    tbl.push_back('{NOP, 0, N, 1, N, N, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, N, N, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, N, N, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, 'hE0, 'h60, N, N, N});
    tbl.push_back('{NOP, 0, N, 0, N, N, N, N, N});
    tbl.push_back('{WIF, 'h01, N, 0, 'hE1, N, N, N, N});
    tbl.push_back('{EI, 0, N, 0, N, N, 0, N, N});
    tbl.push_back('{DI, 0, N, 0, N, N, 0, N, N});
    tbl.push_back('{BND, 0, 0, 0, N, N, 0, N, N});
    tbl.push_back('{BND, 0, 0, 0, N, N, 0, N, N});
    // cancellation by IE write during PUSH_HI
    tbl.push_back('{RETI, 0, N, 0, N, N, 1, N, N});
    tbl.push_back('{BND, 0, 1, 1, N, N, 0, N, N});
    tbl.push_back('{NOP, 0, N, 1, N, N, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, N, N, N, N, N});
    tbl.push_back('{WIE, 'h00, N, 1, N, N, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, 'hE1, 0, N, N, N});
    tbl.push_back('{NOP, 0, N, 0, N, N, N, N, N});
    tbl.push_back('{WIE, 'h1F, N, 0, N, N, N, N, N});
    tbl.push_back('{WIF, 'h11, N, 0, 'hF1, N, N, N, N});
    tbl.push_back('{RETI, 0, N, 0, N, N, 1, N, N});
    tbl.push_back('{BND, 0, 1, 1, N, N, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, N, N, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, N, N, N, N, N});
    tbl.push_back('{WIE, 'h10, N, 1, N, N, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, 'hE1, 'h60, N, N, N});
    tbl.push_back('{NOP, 0, N, 0, N, 0, 0, N, N});
    // HALT, wake with IME=0, halt bug
    tbl.push_back('{HLT, 0, N, 0, N, N, N, 1, 0});
    tbl.push_back('{NOP, 0, N, 0, N, N, N, 1, N});
    tbl.push_back('{WIE, 'h08, N, 0, N, N, N, 1, N});
    tbl.push_back('{IRQ, 'h08, N, 0, 'hE9, N, N, 1, N});
    tbl.push_back('{NOP, 0, 0, 0, N, N, 0, 0, N});
    tbl.push_back('{BND, 0, 0, 0, N, N, N, 0, N});
    tbl.push_back('{HLT, 0, N, 0, N, N, N, 0, 1});
    tbl.push_back('{NOP, 0, N, 0, N, N, N, 0, 0});
    // request colliding with dispatch clear of bit0
    tbl.push_back('{WIE, 'h01, N, 0, N, N, N, N, N});
    tbl.push_back('{WIF, 'h01, N, 0, 'hE1, N, N, N, N});
    tbl.push_back('{RETI, 0, N, 0, N, N, 1, N, N});
    tbl.push_back('{BND, 0, 1, 1, N, N, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, N, N, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, N, N, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, N, N, N, N, N});
    tbl.push_back('{IRQ, 'h01, N, 1, 'hE1, 'h40, N, N, N});
    tbl.push_back('{NOP, 0, N, 0, N, N, N, N, N});
    // start a dispatch, stop in W2
    tbl.push_back('{RETI, 0, N, 0, N, N, 1, N, N});
    tbl.push_back('{BND, 0, 1, 1, N, N, N, N, N});
    tbl.push_back('{NOP, 0, N, 1, N, N, N, N, N});

    rst = 1;
    model_reset();
    do_reset();
    do_reset();
    check("rst_if", if_rdata, 8'hE0);
    check("rst_ie", ie_rdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_vec", vector, 16'h0);
    check("rst_ime", ime, 1'b0);
    check("rst_halt", halted, 1'b0);

    foreach (tbl[i]) run_row(tbl[i]);

    // reset while in W2
    check("w2_busy", busy, 1'b1);
    do_reset();
    check("rst_w2_busy", busy, 1'b0);
    check("rst_w2_if", if_rdata, 8'hE0);
    check("rst_w2_ime", ime, 1'b0);
    check("rst_w2_vec", vector, 16'h0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_w2_idle", busy, 1'b0);

    for (int n = 0; n < 4000; n++) begin
      bit st, ifw, iew, e, d, r, b, h;
      logic [4:0] irq;
      logic [7:0] wd;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        st  = ($urandom_range(0, 3) != 0);
        irq = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
        ifw = ($urandom_range(0, 15) == 0);
        iew = ($urandom_range(0, 15) == 0);
        wd  = ($urandom_range(0, 1) == 0) ? 8'h1F : 8'($urandom);
        e   = st && ($urandom_range(0, 11) == 0);
        d   = st && ($urandom_range(0, 19) == 0);
        r   = st && ($urandom_range(0, 11) == 0);
        h   = st && ($urandom_range(0, 15) == 0);
        b   = st && ($urandom_range(0, 1) == 0);
        apply(st, irq, ifw, iew, wd, e, d, r, b, h);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
